// File: rtl/control_sequencer.sv
// Instruction-cycle controller: steps the T-state counter and decodes the IR
// opcode into one-hot load/enable strobes for the datapath blocks.
module control_sequencer #(
  parameter int LAST_STEP   = 4,
  parameter bit SHORT_CYCLE = 1'b1
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [3:0] opcode_i,
  input  logic       carry_flag_i,
  input  logic       zero_flag_i,
  output logic [2:0] step_o,
  output logic       halted_o,
  output logic       pc_out_o,
  output logic       pc_inc_o,
  output logic       pc_load_o,
  output logic       mar_load_o,
  output logic       ram_out_o,
  output logic       ram_load_o,
  output logic       ir_load_o,
  output logic       ir_out_o,
  output logic       a_load_o,
  output logic       a_out_o,
  output logic       b_load_o,
  output logic       alu_out_o,
  output logic       alu_sub_o,
  output logic       flags_load_o,
  output logic       out_load_o
);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] step_q, step_d;
  logic       halted_q, halted_d;
  logic [2:0] last_step;
  logic [2:0] end_step;
  logic       run;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Final active step of each instruction; undefined opcodes behave as NOP.
  always_comb begin
    case (opcode_i)
      OP_LDA, OP_STA: last_step = 3'd3;
      OP_ADD, OP_SUB: last_step = 3'd4;
      default:        last_step = 3'd2;
    endcase
  end

  assign end_step = SHORT_CYCLE ? last_step : 3'(LAST_STEP);

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (enable_i && !halted_q) begin
      if (step_q == 3'd2 && opcode_i == OP_HLT) begin
        halted_d = 1'b1;
        step_d   = 3'd0;
      end else if (step_q == end_step) begin
        step_d = 3'd0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  assign run      = enable_i & ~halted_q & ~reset_i;
  assign step_o   = step_q;
  assign halted_o = halted_q;

  always_comb begin
    pc_out_o     = 1'b0;
    pc_inc_o     = 1'b0;
    pc_load_o    = 1'b0;
    mar_load_o   = 1'b0;
    ram_out_o    = 1'b0;
    ram_load_o   = 1'b0;
    ir_load_o    = 1'b0;
    ir_out_o     = 1'b0;
    a_load_o     = 1'b0;
    a_out_o      = 1'b0;
    b_load_o     = 1'b0;
    alu_out_o    = 1'b0;
    alu_sub_o    = 1'b0;
    flags_load_o = 1'b0;
    out_load_o   = 1'b0;
    if (run) begin
      case (step_q)
        3'd0: begin
          pc_out_o   = 1'b1;
          mar_load_o = 1'b1;
        end
        3'd1: begin
          ram_out_o = 1'b1;
          ir_load_o = 1'b1;
          pc_inc_o  = 1'b1;
        end
        3'd2: begin
          case (opcode_i)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out_o   = 1'b1;
              mar_load_o = 1'b1;
            end
            OP_LDI: begin
              ir_out_o = 1'b1;
              a_load_o = 1'b1;
            end
            OP_JMP: begin
              ir_out_o  = 1'b1;
              pc_load_o = 1'b1;
            end
            // Conditional jumps: a not-taken branch leaves the bus idle.
            OP_JC: begin
              ir_out_o  = carry_flag_i;
              pc_load_o = carry_flag_i;
            end
            OP_JZ: begin
              ir_out_o  = zero_flag_i;
              pc_load_o = zero_flag_i;
            end
            OP_OUT: begin
              a_out_o    = 1'b1;
              out_load_o = 1'b1;
            end
            default: ;
          endcase
        end
        3'd3: begin
          case (opcode_i)
            OP_LDA: begin
              ram_out_o = 1'b1;
              a_load_o  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out_o = 1'b1;
              b_load_o  = 1'b1;
            end
            OP_STA: begin
              a_out_o    = 1'b1;
              ram_load_o = 1'b1;
            end
            default: ;
          endcase
        end
        3'd4: begin
          if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
            alu_out_o    = 1'b1;
            a_load_o     = 1'b1;
            flags_load_o = 1'b1;
            alu_sub_o    = (opcode_i == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
